// File: rtl/case_9_mul_pkg.sv
// Shared types and the result formatter for the pipelined signed multiply/accumulate core.
// Operands travel sign-extended to OPW_MAX bits, and results are range-checked at FMT_W bits.
package case_9_mul_pkg;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_ACC = 1'b1;

  localparam int OPW_MAX = 32;
  localparam int FMT_W   = 64;

  typedef struct packed {
    logic signed [OPW_MAX-1:0] a;
    logic signed [OPW_MAX-1:0] b;
    logic                      mode;
    logic                      last;
    logic                      valid;
  } stage_t;

  typedef struct packed {
    logic signed [FMT_W-1:0] val;
    logic                    ovf;
  } fmt_t;

  // Checks whether r fits in dw signed bits.
  // The low dw bits of val are either the wrapped value or the clamped value.
  function automatic fmt_t fmt_result(input logic signed [FMT_W-1:0] r,
                                      input int dw,
                                      input logic sat);
    fmt_t f;
    logic signed [FMT_W-1:0] hi;
    logic signed [FMT_W-1:0] lo;
    int sh;
    sh    = FMT_W - dw;
    hi    = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo    = ~hi;
    f.ovf = (r > hi) || (r < lo);
    f.val = (r <<< sh) >>> sh;
    if (sat && f.ovf) begin
      f.val = r[FMT_W-1] ? lo : hi;
    end
    return f;
  endfunction

endpackage

// File: rtl/case_9_mul_pipe_mac_if.sv
// Operand/result handshake bundle between the operand-fetch datapath and the MAC core.
// The master modport drives beats in and accepts results; the slave modport is the core side.
interface case_9_mul_pipe_mac_if #(
  parameter int din0_WIDTH = 11,
  parameter int din1_WIDTH = 7,
  parameter int dout_WIDTH = 11
);

  logic                         in_valid;
  logic                         in_ready;
  logic signed [din0_WIDTH-1:0] din0;
  logic signed [din1_WIDTH-1:0] din1;
  logic                         acc_mode;
  logic                         acc_last;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [dout_WIDTH-1:0] dout;
  logic                         dout_ovf;

  modport master (
    output in_valid, din0, din1, acc_mode, acc_last, out_ready,
    input  in_ready, out_valid, dout, dout_ovf
  );

  modport slave (
    input  in_valid, din0, din1, acc_mode, acc_last, out_ready,
    output in_ready, out_valid, dout, dout_ovf
  );

endinterface

// File: rtl/case_9_mul_fmt.sv
// Combinational result formatter: range flag plus wrap, or saturation when CASE_9_MUL_SAT_EN is defined.
module case_9_mul_fmt
  import case_9_mul_pkg::*;
#(
  parameter int RES_WIDTH  = 24,
  parameter int DOUT_WIDTH = 11
) (
  input  logic signed [RES_WIDTH-1:0]  result,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic                         dout_ovf
);

`ifdef CASE_9_MUL_SAT_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif

  fmt_t f;
  logic unused_val;

  assign f          = fmt_result(FMT_W'(result), DOUT_WIDTH, SAT);
  assign dout       = f.val[DOUT_WIDTH-1:0];
  assign dout_ovf   = f.ovf;
  assign unused_val = ^f.val;

endmodule

// File: rtl/case_9_mul_pipe_mac.sv
// Pipelined signed multiplier with accumulate mode, clock enable and valid/ready backpressure.
// Output saturates instead of wrapping when CASE_9_MUL_SAT_EN is defined.
module case_9_mul_pipe_mac
  import case_9_mul_pkg::*;
#(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 11,
  parameter int din1_WIDTH = 7,
  parameter int dout_WIDTH = 11,
  parameter int ACC_WIDTH  = 24
) (
  input logic                    clk,
  input logic                    reset,
  input logic                    ce,
  case_9_mul_pipe_mac_if.slave   bus
);

  localparam int PW = din0_WIDTH + din1_WIDTH;

  typedef struct packed {
    logic signed [PW-1:0] prod;
    logic                 mode;
    logic                 last;
    logic                 valid;
  } prod_t;

  if (NUM_STAGE < 2 || NUM_STAGE > 8 || ACC_WIDTH < PW || ACC_WIDTH > FMT_W ||
      dout_WIDTH >= FMT_W || din0_WIDTH > OPW_MAX || din1_WIDTH > OPW_MAX || ID < 0) begin : g_param_check
    $error("case_9_mul_pipe_mac: illegal parameter set");
  end

  logic                         adv;
  logic                         out_valid_q;
  logic signed [dout_WIDTH-1:0] dout_q;
  logic                         ovf_q;
  stage_t                       s1;
  logic signed [PW-1:0]         p0;
  prod_t                        taps [NUM_STAGE-1];
  prod_t                        fin;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [ACC_WIDTH-1:0]  pext;
  logic signed [ACC_WIDTH-1:0]  sum;
  logic signed [ACC_WIDTH-1:0]  res;
  logic signed [dout_WIDTH-1:0] fmt_dout;
  logic                         fmt_ovf;
  logic                         unused_ops;

  // The whole pipe moves as one; a held result blocks everything behind it.
  assign adv           = ce & (~out_valid_q | bus.out_ready);
  assign bus.in_ready  = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.dout      = dout_q;
  assign bus.dout_ovf  = ovf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
    end else if (adv) begin
      s1.a     <= OPW_MAX'(bus.din0);
      s1.b     <= OPW_MAX'(bus.din1);
      s1.mode  <= bus.acc_mode;
      s1.last  <= bus.acc_last;
      s1.valid <= bus.in_valid;
    end
  end

  assign p0         = PW'($signed(s1.a[din0_WIDTH-1:0])) * PW'($signed(s1.b[din1_WIDTH-1:0]));
  assign unused_ops = ^{s1.a, s1.b};
  assign taps[0]    = '{prod: p0, mode: s1.mode, last: s1.last, valid: s1.valid};

  for (genvar i = 1; i < NUM_STAGE - 1; i++) begin : g_prod
    prod_t q;
    always_ff @(posedge clk) begin
      if (reset) begin
        q <= '0;
      end else if (adv) begin
        q <= taps[i-1];
      end
    end
    assign taps[i] = q;
  end

  assign fin  = taps[NUM_STAGE-2];
  assign pext = ACC_WIDTH'(fin.prod);
  assign sum  = acc + pext;
  assign res  = (fin.mode == MODE_ACC) ? sum : pext;

  case_9_mul_fmt #(
    .RES_WIDTH  (ACC_WIDTH),
    .DOUT_WIDTH (dout_WIDTH)
  ) u_fmt (
    .result   (res),
    .dout     (fmt_dout),
    .dout_ovf (fmt_ovf)
  );

  // Open accumulations only fold into acc; plain beats bypass it entirely.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc         <= '0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      ovf_q       <= 1'b0;
    end else if (adv) begin
      out_valid_q <= 1'b0;
      if (fin.valid) begin
        if (fin.mode == MODE_ACC && !fin.last) begin
          acc <= sum;
        end else begin
          out_valid_q <= 1'b1;
          dout_q      <= fmt_dout;
          ovf_q       <= fmt_ovf;
          if (fin.mode == MODE_ACC) begin
            acc <= '0;
          end
        end
      end
    end
  end

endmodule

// File: doc/case_9_mul_pipe_mac.md
# case_9_mul_pipe_mac

Parametrised, pipelined signed multiplier with a valid/ready handshake, a clock enable and a selectable multiply-accumulate mode. It generalises the single-cycle signed multiplier cores in this design: stage count, operand widths and accumulator width are configurable, and backpressure and per-beat accumulate/plain mode are added. It sits between the operand-fetch datapath and the writeback buffer.

## Interface
- `ID`, 1, instance tag, no functional effect
- `NUM_STAGE`, 3, pipeline depth in cycles, legal range 2..8
- `din0_WIDTH`, 11, signed operand A width
- `din1_WIDTH`, 7, signed operand B width
- `dout_WIDTH`, 11, signed result width
- `ACC_WIDTH`, 24, signed accumulator width, ≥ din0_WIDTH+din1_WIDTH

Ports:
- `clk`  in  1  clock, rising edge
- `reset`  in  1  synchronous, active-high
- `ce`  in  1  global clock enable
- `in_valid`  in  1  input beat valid
- `in_ready`  out  1  input beat accepted when high with in_valid
- `din0`  in  din0_WIDTH  operand A, signed
- `din1`  in  din1_WIDTH  operand B, signed
- `acc_mode`  in  1  0 = plain multiply, 1 = accumulate
- `acc_last`  in  1  closes the accumulation (only meaningful when acc_mode=1)
- `out_valid`  out  1  result valid
- `out_ready`  in  1  downstream accepts result
- `dout`  out  dout_WIDTH  signed result
- `dout_ovf`  out  1  result not representable in dout_WIDTH

## Operation
- Advance condition: `adv = ce & (~out_valid | out_ready)`. `in_ready = adv`. The whole pipeline moves together or stalls.
- Stage 1 registers din0, din1, acc_mode, acc_last and a valid bit. Stages 2..NUM_STAGE-1 carry the full signed product (din0_WIDTH+din1_WIDTH bits). Stage NUM_STAGE is the accumulate/format register.
- Plain beat reaching the final stage: result = product sign-extended. out_valid=1. Accumulator untouched.
- Accumulate beat with acc_last=0: `acc <= acc + sext(product)`. No output.
- Accumulate beat with acc_last=1: result = acc + sext(product). out_valid=1. acc <= 0.
- The accumulator wraps modulo 2^ACC_WIDTH (two's complement), with no flag.
- Format: dout_ovf=1 when the result lies outside [-2^(dout_WIDTH-1), 2^(dout_WIDTH-1)-1]. dout is given by the Configuration section.
- Plain beats interleaved inside an open accumulation pass through without disturbing acc.
- reset: all valid bits 0, acc 0, dout 0, dout_ovf 0, out_valid 0. In-flight beats and any partial accumulation are discarded. in_ready follows adv on the next cycle.
- ce=0: every register holds, in_ready=0, and out_valid/dout stay stable.

## Timing
- Latency: a beat accepted at edge N gives out_valid at edge N+NUM_STAGE, with no stall and ce=1.
- Throughput: one beat per cycle.
- Handshake: dout/dout_ovf hold while out_valid=1 and out_ready=0. in_ready stays low for those same cycles.
- Output transfer and new input acceptance can happen in the same cycle.

## Configuration
- `CASE_9_MUL_SAT_EN` defined: on overflow, dout saturates to the signed min or max of dout_WIDTH.
- Not defined: dout = low dout_WIDTH bits of the result (wrap).
- dout_ovf is generated identically in both builds.

## Structure
- Package `case_9_mul_pkg`:
  - mode localparams `MODE_MUL`/`MODE_ACC`
  - stage-payload struct (operands, mode, last, valid)
  - function `fmt_result`, which does the range check plus saturate/wrap
- One sub-module `case_9_mul_fmt`: combinational formatter, result in → dout and dout_ovf out, honouring the macro.
- The pipeline delay uses a generate loop over NUM_STAGE-2 product registers.

## Test plan
All scenarios use default parameters, NUM_STAGE=3, out_ready=1 and ce=1 unless stated.
- Plain multiply: din0=-25, din1=13 accepted at cycle 0 → out_valid at cycle 3, dout=-325 (0x6BB), dout_ovf=0.
- Overflow: din0=1023, din1=63 → dout_ovf=1; dout=961 without the macro, 1023 with it. Then din0=-1024, din1=-64 → dout=0 without the macro, 1023 with it.
- MAC: (10,3,acc), then (-4,5,acc), then (7,7,acc,last) on consecutive cycles → exactly one out_valid with dout=59. A following (2,2,acc,last) gives dout=4, proving acc was cleared.
- Backpressure: 5 plain beats (k,1) for k=1..5, with out_ready held low for 4 cycles after the first result → in_ready low during the stall, outputs 1..5 in order, none lost or duplicated.
- Reset mid-operation: (10,3,acc) and (-4,5,acc) accepted, reset pulsed for 1 cycle, then (3,2,acc,last) → dout=6, and no output is produced from the discarded beats.
- Clock enable: ce low for 3 cycles while 2 beats are in flight → outputs and in_ready frozen, then results arrive 3 cycles later with correct values.
